// File: rtl/audio_serializer_if.sv
// audio_serializer_if
//   Groups the sample feed from the music player and the codec-facing serial
//   stream of the audio serializer into one bundle.
//
//   Signals:
//     sample       - signed PCM sample presented by the music player
//     play         - 1 = transmit sample, 0 = transmit zeros (clocks keep running)
//     bclk         - codec bit clock
//     lrclk        - 0 = left channel bits, 1 = right channel bits
//     sdata        - serial data, MSB first, changes on bclk falling edge
//     new_frame    - high during the left half-frame; paces the upstream producer
//     sample_taken - one-clk pulse when sample is latched
//
//   Modports:
//     master - the side that supplies sample/play and watches the outputs
//     slave  - the serializer itself
interface audio_serializer_if #(
    parameter int SAMPLE_BITS = 16
);
    logic [SAMPLE_BITS-1:0] sample;
    logic                   play;
    logic                   bclk;
    logic                   lrclk;
    logic                   sdata;
    logic                   new_frame;
    logic                   sample_taken;

    modport master (
        output sample,
        output play,
        input  bclk,
        input  lrclk,
        input  sdata,
        input  new_frame,
        input  sample_taken
    );

    modport slave (
        input  sample,
        input  play,
        output bclk,
        output lrclk,
        output sdata,
        output new_frame,
        output sample_taken
    );
endinterface

// File: rtl/audio_serializer.sv
// audio_serializer
//   Serialises one 16-bit PCM sample per audio frame to the codec as a
//   left-justified stereo stream (same sample on both channels), generating
//   bclk and lrclk, plus the new_frame level that paces the upstream player.
//
//   Ports:
//     clk   - system clock
//     reset - asynchronous, active-high reset; all outputs return to 0 at once
//     bus   - audio_serializer_if.slave (sample/play in; bclk, lrclk, sdata,
//             new_frame, sample_taken out)
//
//   Parameters:
//     CLK_DIV     - clk cycles per bclk half-period (2..255)
//     SAMPLE_BITS - bits per channel; the 5-bit frame counter assumes 16
module audio_serializer #(
    parameter int CLK_DIV     = 4,
    parameter int SAMPLE_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    audio_serializer_if.slave   bus
);
    localparam logic [7:0] DIV_LAST    = 8'(CLK_DIV - 1);
    localparam logic [4:0] RIGHT_START = 5'(SAMPLE_BITS);
    localparam int         MSB         = SAMPLE_BITS - 1;

    logic [7:0]             div_cnt_reg;
    logic [4:0]             bit_cnt_reg;
    logic [4:0]             bit_cnt_next;
    logic [SAMPLE_BITS-1:0] hold_reg;
    logic [SAMPLE_BITS-1:0] shreg_reg;
    logic [SAMPLE_BITS-1:0] shreg_next;
    logic [SAMPLE_BITS-1:0] frame_word;
    logic                   bclk_reg;
    logic                   lrclk_reg;
    logic                   sdata_reg;
    logic                   new_frame_reg;
    logic                   sample_taken_reg;
    logic                   toggle;
    logic                   fall;

    assign toggle       = (div_cnt_reg == DIV_LAST);
    // A toggle while bclk is high is the falling edge; all serial state moves here.
    assign fall         = toggle && bclk_reg;
    assign bit_cnt_next = bit_cnt_reg + 5'd1;
    // Muting is applied at latch time so the right half repeats exactly what
    // the left half sent, whatever play does mid-frame.
    assign frame_word   = bus.play ? bus.sample : '0;

    // Left shift by one with zero fill.
    assign shreg_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < SAMPLE_BITS; gi++) begin : g_shift
            assign shreg_next[gi] = shreg_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg      <= 8'd0;
            // 31 so that the first falling event wraps to 0 and opens a frame.
            bit_cnt_reg      <= 5'd31;
            hold_reg         <= '0;
            shreg_reg        <= '0;
            bclk_reg         <= 1'b0;
            lrclk_reg        <= 1'b0;
            sdata_reg        <= 1'b0;
            new_frame_reg    <= 1'b0;
            sample_taken_reg <= 1'b0;
        end else begin
            sample_taken_reg <= 1'b0;

            if (toggle) begin
                div_cnt_reg <= 8'd0;
                bclk_reg    <= ~bclk_reg;
            end else begin
                div_cnt_reg <= div_cnt_reg + 8'd1;
            end

            if (fall) begin
                bit_cnt_reg <= bit_cnt_next;
                if (bit_cnt_next == 5'd0) begin
                    hold_reg         <= frame_word;
                    shreg_reg        <= frame_word;
                    sdata_reg        <= frame_word[MSB];
                    lrclk_reg        <= 1'b0;
                    new_frame_reg    <= 1'b1;
                    sample_taken_reg <= 1'b1;
                end else if (bit_cnt_next == RIGHT_START) begin
                    shreg_reg     <= hold_reg;
                    sdata_reg     <= hold_reg[MSB];
                    lrclk_reg     <= 1'b1;
                    new_frame_reg <= 1'b0;
                end else begin
                    shreg_reg <= shreg_next;
                    sdata_reg <= shreg_reg[MSB-1];
                end
            end
        end
    end

    assign bus.bclk         = bclk_reg;
    assign bus.lrclk        = lrclk_reg;
    assign bus.sdata        = sdata_reg;
    assign bus.new_frame    = new_frame_reg;
    assign bus.sample_taken = sample_taken_reg;
endmodule

// File: tb/tb_audio_serializer.sv
// tb_audio_serializer
//   Scoreboard bench: the stimulus process decides which word each frame must
//   carry and queues it; the monitor derives every output from the elapsed clk
//   count (frame/bit position arithmetic) and pops a queued word at each frame
//   start.
module tb_audio_serializer;
    localparam int D     = 2;          // CLK_DIV under test
    localparam int BITC  = 2 * D;      // clk per bclk period
    localparam int FRAME = 64 * D;     // clk per frame
    localparam int NF    = 10;         // frames before the mid-frame reset

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    audio_serializer_if #(.SAMPLE_BITS(16)) bus ();

    audio_serializer #(.CLK_DIV(D), .SAMPLE_BITS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int  tick     = 0;
    int  rel_tick = 0;
    bit  running  = 1'b0;
    int  total    = 0;
    int  bad      = 0;
    int  frames_model = 0;
    int  pulses_dut   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] cur_val = 16'h0000;

    always @(posedge clk) tick <= tick + 1;

    function automatic int cur_c();
        return tick - rel_tick;
    endfunction

    task automatic check1(input string name, input logic act, input logic expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at c=%0d: got %b want %b", name, cur_c(), act, expv);
        end
    endtask

    task automatic wait_c(input int target);
        while (cur_c() < target) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    int   mc, mt, mp, mb;
    logic e_bclk, e_lr, e_nf, e_st, e_sd;
    initial begin
        forever begin
            @(negedge clk);
            if (running) begin
                mc     = cur_c();
                e_bclk = ((mc / D) % 2) == 1;
                e_lr = 1'b0; e_nf = 1'b0; e_st = 1'b0; e_sd = 1'b0;
                if (mc >= 2 * D) begin
                    mt = mc - 2 * D;
                    mp = mt % FRAME;
                    mb = mp / BITC;
                    if (mp == 0) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL queue_empty at c=%0d: got no expected word want one", mc);
                            cur_val = 16'h0000;
                        end else begin
                            cur_val = exp_q.pop_front();
                        end
                        frames_model++;
                        $display("frame %0d start c=%0d word=%h", frames_model, mc, cur_val);
                    end
                    e_lr = (mb >= 16);
                    e_nf = (mb < 16);
                    e_st = (mp == 0);
                    e_sd = cur_val[15 - (mb % 16)];
                end
                if (bus.sample_taken === 1'b1) pulses_dut++;
                check1("bclk",         bus.bclk,         e_bclk);
                check1("lrclk",        bus.lrclk,        e_lr);
                check1("new_frame",    bus.new_frame,    e_nf);
                check1("sample_taken", bus.sample_taken, e_st);
                check1("sdata",        bus.sdata,        e_sd);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Per frame k: inputs set at bit 5 and again at bit 20; the bit-20 values
    // are what the next frame start latches.
    logic [15:0] s1_tab [3] = '{16'hFFFF, 16'h8001, 16'h7FFE};
    logic        p1_tab [3] = '{1'b0, 1'b1, 1'b1};
    logic [15:0] s2_tab [3] = '{16'hFFFF, 16'h8001, 16'h7FFE};
    logic        p2_tab [3] = '{1'b0, 1'b1, 1'b0};

    task automatic run_frames(input int count, input bit directed);
        int fstart;
        for (int k = 0; k < count; k++) begin
            fstart = 2 * D + k * FRAME;
            wait_c(fstart + 5 * BITC + 1);
            if (directed && k < 3) begin
                bus.sample = s1_tab[k]; bus.play = p1_tab[k];
            end else begin
                bus.sample = 16'($urandom); bus.play = ($urandom_range(0, 3) != 0);
            end
            wait_c(fstart + 20 * BITC + 1);
            if (directed && k < 3) begin
                bus.sample = s2_tab[k]; bus.play = p2_tab[k];
            end else if ($urandom_range(0, 1) == 1) begin
                bus.sample = 16'($urandom); bus.play = ($urandom_range(0, 3) != 0);
            end
            exp_q.push_back(bus.play ? bus.sample : 16'h0000);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        exp_q.push_back(bus.play ? bus.sample : 16'h0000);
        rel_tick = tick;
        reset    = 1'b0;
        running  = 1'b1;
    endtask

    initial begin
        bus.sample = 16'hA5C3;
        bus.play   = 1'b1;
        repeat (3) @(negedge clk);
        check1("rst_bclk",      bus.bclk,         1'b0);
        check1("rst_lrclk",     bus.lrclk,        1'b0);
        check1("rst_sdata",     bus.sdata,        1'b0);
        check1("rst_new_frame", bus.new_frame,    1'b0);
        check1("rst_taken",     bus.sample_taken, 1'b0);

        release_reset();
        run_frames(NF, 1'b1);

        // Abort frame NF at bit 25 (right half) while bclk is high.
        wait_c(2 * D + NF * FRAME + 25 * BITC + D);
        check1("pre_abort_lrclk", bus.lrclk, 1'b1);
        check1("pre_abort_bclk",  bus.bclk,  1'b1);
        #2;
        running = 1'b0;
        reset   = 1'b1;
        #1;
        check1("async_bclk",      bus.bclk,         1'b0);
        check1("async_lrclk",     bus.lrclk,        1'b0);
        check1("async_sdata",     bus.sdata,        1'b0);
        check1("async_new_frame", bus.new_frame,    1'b0);
        check1("async_taken",     bus.sample_taken, 1'b0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        bus.sample = 16'($urandom);
        bus.play   = 1'b1;
        release_reset();
        run_frames(3, 1'b0);
        wait_c(2 * D + 3 * FRAME + FRAME / 2);
        running = 1'b0;

        total++;
        if (pulses_dut != frames_model) begin
            bad++;
            $display("FAIL pulse_count: got %0d want %0d", pulses_dut, frames_model);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/audio_serializer.md
Name: audio_serializer

Overview:
- Downstream stage of the music player. It consumes the 16-bit `sample` word and serialises it to the audio codec as a left-justified stereo stream.
- The same sample is sent on both channels.
- It generates the bit clock and LR clock for the codec.
- It also generates the `new_frame` level that paces sample production upstream: one rising edge per audio frame.

Parameters:
- CLK_DIV, 4: clk cycles per bclk half-period. Legal range 2..255.
- SAMPLE_BITS, 16: bits per channel. Fixed at 16; frame length is 2*SAMPLE_BITS = 32 bclk periods.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sample  input  16  signed PCM sample from the music player
- play  input  1  1 = transmit sample; 0 = transmit zeros (mute), clocks keep running
- bclk  output  1  codec bit clock
- lrclk  output  1  0 = left channel bits, 1 = right channel bits
- sdata  output  1  serial data, MSB first, changes on bclk falling edge
- new_frame  output  1  high during left half-frame, low during right half-frame
- sample_taken  output  1  one-clk pulse when sample is latched

Behaviour:
- Reset (asynchronous, immediate) sets:
  - div_cnt=0, bit_cnt=31, hold=0, shreg=0.
  - bclk=0, lrclk=0, sdata=0, new_frame=0, sample_taken=0.
- Divider:
  - div_cnt (8 bits) increments every clk.
  - At div_cnt==CLK_DIV-1: div_cnt<=0 and bclk<=~bclk.
  - bclk period = 2*CLK_DIV clk cycles.
- Falling event: a toggle while bclk==1. All serial updates happen only on the falling event, in the same clk edge as bclk goes 0.
- bit_cnt (5 bits) increments mod 32 on each falling event. Call the new value n.
- n==0 (frame start):
  - hold<=play?sample:16'h0000 and shreg<= the same value.
  - sdata<= that value's bit 15; lrclk<=0; new_frame<=1.
  - sample_taken<=1 for exactly one clk.
- n==16 (right start):
  - shreg<=hold and sdata<=hold[15].
  - lrclk<=1; new_frame<=0.
- Other n:
  - shreg<=shreg<<1 and sdata<=shreg[14] (next bit).
  - lrclk and new_frame unchanged.
- sample_taken is 0 in all other cycles.
- sample and play are sampled only at frame start. Changes mid-frame have no effect until the next frame.
- The right channel always repeats the left value latched at frame start, even if play changes mid-frame.
- Startup timing after reset release:
  - First bclk rise at clk cycle CLK_DIV.
  - First falling event (frame start, n=0) at cycle 2*CLK_DIV.
  - Until then all outputs hold their reset values.
- Rates:
  - Frame period = 64*CLK_DIV clk cycles.
  - new_frame is high for 32*CLK_DIV cycles, at least 64 cycles. That is long enough for the upstream two-flop synchroniser and edge detector to see exactly one rising edge per frame.
- Latency: a sample latched at frame start appears on sdata MSB in the same clk. Upstream has the whole frame to present the next sample.
- Reset mid-frame aborts the frame and returns every output to 0 immediately. The normal startup sequence then repeats after release.
- No handshake backpressure: a sample not updated in time is simply retransmitted.

Test Plan:
- Reset and startup, CLK_DIV=2: assert reset, release → all outputs 0; bclk rises at cycle 2, falls at cycle 4; at cycle 4 new_frame=1, lrclk=0, sample_taken pulses 1 clk.
- Serial data, sample=16'hA5C3, play=1, CLK_DIV=2:
  - sdata sampled on bclk rising edges reads 1010_0101_1100_0011 with lrclk=0.
  - It then reads the same 16 bits with lrclk=1.
  - lrclk is low 64 clk, then high 64 clk.
- Mute: play=0, sample=16'hFFFF → sdata=0 for the entire frame; bclk, lrclk and new_frame keep toggling with 128-clk frame period.
- Mid-frame change: sample=16'h8001 at frame start, switched to 16'h7FFE at bit 5, and play dropped at bit 20 → left and right both carry 16'h8001; the next frame carries 0 (play=0).
- Pacing: run 10 frames, CLK_DIV=4 → new_frame rising edges every 256 clk, each high 128 clk; exactly 10 sample_taken pulses, each coincident with a new_frame rise.
- Async reset at bit 9 of the right half (bit_cnt=25) → bclk, lrclk, sdata and new_frame go 0 without waiting for a clk edge; after release, the frame restarts at cycle 2*CLK_DIV with a fresh sample latch.
